// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out stage.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo counter with synchronous clear; flags when it sits at its maximum.
module bit_counter #(
  parameter int MAX = 15,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  assign at_max = (cnt == CW'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_max ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out stage with valid/ready load and a stallable serial side.
// Back-to-back words load on the final-bit edge so the serial stream has no gap.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    cnt;
  logic             at_max;
  logic             in_shift;
  logic             word_done;
  logic             accept;

  assign in_shift   = (state == ST_SHIFT);
  assign sout_valid = in_shift;
  assign busy       = in_shift;
  assign last       = in_shift & (cnt == CW'(WIDTH - 1));
  assign sout       = in_shift & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

  assign word_done  = in_shift & at_max & shift_en;
  // Ready depends on shift_en so a new word can replace the final bit in the same edge.
  assign load_ready = ~in_shift | word_done;
  assign accept     = load_valid & load_ready;

  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  bit_counter #(
    .MAX (WIDTH - 1),
    .CW  (CW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept | word_done),
    .inc    (in_shift & shift_en),
    .cnt    (cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= ST_SHIFT;
      shreg <= d;
    end else if (in_shift && shift_en) begin
      shreg <= shreg_next;
      if (word_done) state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: an MSB-first and an LSB-first instance share stimulus
// and are checked every cycle against a word/bit-position model, plus literal sequences.
module tb_piso_shift_register;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [W-1:0]  d = '0;
  logic          shift_en = 1'b0;

  logic ready_m, sout_m, valid_m, last_m, busy_m;
  logic ready_l, sout_l, valid_l, last_l, busy_l;

  int total = 0;
  int bad = 0;

  // model: the word being sent and how many of its bits have already gone out
  bit          active = 1'b0;
  logic [W-1:0] word = '0;
  int          pos = 0;

  // capture of delivered bits and event counts while sout_valid
  logic [63:0] cap_m = '0;
  logic [63:0] cap_l = '0;
  int          vcnt = 0;
  int          lastcnt = 0;
  int          rdycnt = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (ready_m),
    .d          (d),
    .shift_en   (shift_en),
    .sout       (sout_m),
    .sout_valid (valid_m),
    .last       (last_m),
    .busy       (busy_m)
  );

  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (ready_l),
    .d          (d),
    .shift_en   (shift_en),
    .sout       (sout_l),
    .sout_valid (valid_l),
    .last       (last_l),
    .busy       (busy_l)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active = 1'b0;
      pos    = 0;
      word   = '0;
    end else begin
      bit rdy;
      rdy = !active || (pos == W - 1 && shift_en);
      if (load_valid && rdy) begin
        word   = d;
        pos    = 0;
        active = 1'b1;
      end else if (active && shift_en) begin
        if (pos == W - 1) active = 1'b0;
        else pos = pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic e_sm, e_sl, e_last, e_rdy;
    e_sm   = active ? word[W-1-pos] : 1'b0;
    e_sl   = active ? word[pos] : 1'b0;
    e_last = active && (pos == W - 1);
    e_rdy  = !active || (e_last && shift_en);
    chk("sout_m", sout_m, e_sm);
    chk("valid_m", valid_m, active);
    chk("last_m", last_m, e_last);
    chk("busy_m", busy_m, active);
    chk("ready_m", ready_m, e_rdy);
    chk("sout_l", sout_l, e_sl);
    chk("valid_l", valid_l, active);
    chk("last_l", last_l, e_last);
    chk("busy_l", busy_l, active);
    chk("ready_l", ready_l, e_rdy);
    if (reset && valid_m) begin
      vcnt++;
      if (shift_en) begin
        cap_m = {cap_m[62:0], sout_m};
        cap_l = {cap_l[62:0], sout_l};
      end
      if (last_m && shift_en) lastcnt++;
      if (ready_m) rdycnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cap();
    cap_m = '0; cap_l = '0; vcnt = 0; lastcnt = 0; rdycnt = 0;
  endtask

  task automatic send(input logic [W-1:0] w, input int stall_after, input int stall_len);
    int n, stalls;
    clr_cap();
    load_valid = 1'b1;
    d = w;
    shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    d = W'($urandom);
    n = 0;
    stalls = 0;
    while (n < W) begin
      if (n == stall_after && stalls < stall_len) begin
        shift_en = 1'b0;
        stalls++;
      end else begin
        shift_en = 1'b1;
        n++;
      end
      step();
    end
    shift_en = 1'b0;
  endtask

  initial begin
    // reset held with a word offered
    reset = 1'b0; load_valid = 1'b1; d = 16'hFFFF; shift_en = 1'b1;
    repeat (2) step();
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_sout", sout_m, 1'b0);
    chk("rst_ready", ready_m, 1'b1);
    reset = 1'b1;
    step();
    chk("rel_busy", busy_m, 1'b1);
    chk("rel_sout", sout_m, 1'b1);
    load_valid = 1'b0;
    repeat (16) step();
    chk("rel_done", busy_m, 1'b0);
    shift_en = 1'b0;
    step();

    send(16'h000F, 99, 0);
    chk("w000f_m", cap_m[15:0], 64'h000F);
    chk("w000f_l", cap_l[15:0], 64'hF000);
    chk("w000f_last", lastcnt, 1);
    chk("w000f_vcnt", vcnt, 16);
    chk("w000f_busy", busy_m, 1'b0);

    send(16'h8001, 99, 0);
    chk("w8001_l", cap_l[15:0], 64'h8001);
    chk("w8001_m", cap_m[15:0], 64'h8001);
    chk("w8001_last", lastcnt, 1);

    send(16'hA5A5, 4, 3);
    chk("stall_m", cap_m[15:0], 64'hA5A5);
    chk("stall_l", cap_l[15:0], 64'hA5A5);
    chk("stall_vcnt", vcnt, 19);
    chk("stall_last", lastcnt, 1);

    // back-to-back words with load_valid held
    clr_cap();
    load_valid = 1'b1; d = 16'hA5A5; shift_en = 1'b1;
    step();
    d = 16'h5A5A;
    repeat (16) step();
    load_valid = 1'b0;
    repeat (16) step();
    shift_en = 1'b0;
    chk("b2b_m", cap_m[31:0], 64'hA5A55A5A);
    chk("b2b_l", cap_l[31:0], 64'hA5A55A5A);
    chk("b2b_vcnt", vcnt, 32);
    chk("b2b_rdy", rdycnt, 2);
    chk("b2b_last", lastcnt, 2);

    // reset between edges in the middle of a word
    clr_cap();
    load_valid = 1'b1; d = 16'hFFFF; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (7) step();
    #2 reset = 1'b0;
    #1;
    chk("mid_valid_m", valid_m, 1'b0);
    chk("mid_valid_l", valid_l, 1'b0);
    chk("mid_last", last_m, 1'b0);
    chk("mid_busy", busy_m, 1'b0);
    chk("mid_ready", ready_m, 1'b1);
    chk("mid_lastcnt", lastcnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    shift_en = 1'b0;
    step();
    send(16'h1234, 99, 0);
    chk("after_m", cap_m[15:0], 64'h1234);
    chk("after_l", cap_l[15:0], 64'h2C48);
    chk("after_vcnt", vcnt, 16);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      shift_en   = ($urandom_range(0, 3) != 0);
      d          = W'($urandom);
      step();
    end
    load_valid = 1'b0;
    shift_en = 1'b1;
    repeat (20) step();
    chk("final_idle", busy_m, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
